change_dispenser: RTL and testbench

Change-return controller for the vending machine.
- Accepts a change amount in cents and sequences the coin hopper outputs (outquarter, outdime, outnickel) one coin at a time, using a greedy algorithm.
- Tracks per-denomination coin inventory, replenished by accepted coin-input pulses.
- Sits between the vending FSM, which requests change, and the physical coin hopper.

---
 rtl/vending_pkg.sv | 25 ++
 rtl/coin_inventory.sv | 47 ++++
 rtl/change_dispenser.sv | 201 ++++++++++++++++++++
 tb/tb_change_dispenser.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending-machine change path.
//   coin_e      : coin denomination selector
//   Q/D/N_VAL   : coin values in cents
//   chg_state_e : change_dispenser FSM states
package vending_pkg;

    typedef enum logic [1:0] {
        COIN_Q,
        COIN_D,
        COIN_N
    } coin_e;

    localparam int unsigned Q_VAL = 25;
    localparam int unsigned D_VAL = 10;
    localparam int unsigned N_VAL = 5;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        GAP,
        DONE
    } chg_state_e;

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin counter.
//   clk, reset : clock, asynchronous active-high reset (count reloads INIT)
//   inc        : one coin added this cycle (saturates at all-ones)
//   dec        : one coin dispensed this cycle (caller only asserts when count > 0)
//   count      : current number of coins
//   empty      : count == 0
module coin_inventory #(
    parameter int CNT_W = 6,
    parameter int INIT  = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A simultaneous inc and dec cancel out, so the count is left untouched.
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q != CNT_MAX) begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= CNT_INIT;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change-return controller: pays a requested amount with the greedy coin
// order quarter > dime > nickel, one registered eject pulse at a time, and
// tracks the coin inventory of each denomination.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_amount: change request, taken while req_ready is high
//   req_ready           : controller idle
//   refill_q/d/n        : one coin of that kind added per high cycle
//   outquarter/dime/nickel : one-cycle hopper eject pulses
//   busy                : a request is in progress
//   done, short_chg     : completion pulse; short_chg set if not fully paid
//   remaining           : unpaid cents of the last request
//   coin_empty          : {q,d,n} empty flags, only with CHANGE_EMPTY_FLAGS_EN
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W     = 8,
    parameter int CNT_W     = 6,
    parameter int INIT_Q    = 20,
    parameter int INIT_D    = 20,
    parameter int INIT_N    = 20,
    parameter int PULSE_GAP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             refill_q,
    input  logic             refill_d,
    input  logic             refill_n,
    output logic             outquarter,
    output logic             outdime,
    output logic             outnickel,
    output logic             busy,
    output logic             done,
    output logic             short_chg,
    output logic [AMT_W-1:0] remaining
`ifdef CHANGE_EMPTY_FLAGS_EN
    ,
    output logic [2:0]       coin_empty
`endif
);
    localparam logic [AMT_W-1:0] Q_AMT = AMT_W'(Q_VAL);
    localparam logic [AMT_W-1:0] D_AMT = AMT_W'(D_VAL);
    localparam logic [AMT_W-1:0] N_AMT = AMT_W'(N_VAL);
    localparam logic [3:0]       GAP_LOAD = 4'(PULSE_GAP - 1);

    chg_state_e       state_q, state_d;
    coin_e            coin_q, coin_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [3:0]       gap_q, gap_d;
    logic [2:0]       out_q, out_d;        // {quarter, dime, nickel}
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] q_cnt, d_cnt, n_cnt;
    logic             q_empty, d_empty, n_empty;
    logic             dec_q, dec_d, dec_n;

    // The inventory is decremented at the end of the PULSE cycle; the count
    // check keeps a dispense from ever reaching an empty counter.
    assign dec_q = (state_q == PULSE) && (coin_q == COIN_Q) && (q_cnt != '0);
    assign dec_d = (state_q == PULSE) && (coin_q == COIN_D) && (d_cnt != '0);
    assign dec_n = (state_q == PULSE) && (coin_q == COIN_N) && (n_cnt != '0);

    coin_inventory #(.CNT_W(CNT_W), .INIT(INIT_Q)) u_inv_q (
        .clk(clk), .reset(reset), .inc(refill_q), .dec(dec_q),
        .count(q_cnt), .empty(q_empty)
    );
    coin_inventory #(.CNT_W(CNT_W), .INIT(INIT_D)) u_inv_d (
        .clk(clk), .reset(reset), .inc(refill_d), .dec(dec_d),
        .count(d_cnt), .empty(d_empty)
    );
    coin_inventory #(.CNT_W(CNT_W), .INIT(INIT_N)) u_inv_n (
        .clk(clk), .reset(reset), .inc(refill_n), .dec(dec_n),
        .count(n_cnt), .empty(n_empty)
    );

    // Output registers are loaded on the transition into the state that owns
    // them, so the eject pulse coincides with PULSE and done with DONE.
    always_comb begin
        state_d     = state_q;
        coin_d      = coin_q;
        rem_d       = rem_q;
        gap_d       = gap_q;
        out_d       = 3'b000;
        done_d      = 1'b0;
        short_d     = short_q;
        remaining_d = remaining_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rem_d   = req_amount;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (rem_q >= Q_AMT && !q_empty) begin
                    coin_d  = COIN_Q;
                    out_d   = 3'b100;
                    state_d = PULSE;
                end else if (rem_q >= D_AMT && !d_empty) begin
                    coin_d  = COIN_D;
                    out_d   = 3'b010;
                    state_d = PULSE;
                end else if (rem_q >= N_AMT && !n_empty) begin
                    coin_d  = COIN_N;
                    out_d   = 3'b001;
                    state_d = PULSE;
                end else begin
                    done_d      = 1'b1;
                    short_d     = (rem_q != '0);
                    remaining_d = rem_q;
                    state_d     = DONE;
                end
            end
            PULSE: begin
                case (coin_q)
                    COIN_Q:  rem_d = rem_q - Q_AMT;
                    COIN_D:  rem_d = rem_q - D_AMT;
                    default: rem_d = rem_q - N_AMT;
                endcase
                gap_d   = GAP_LOAD;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = SELECT;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_q       <= 3'b000;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            remaining_q <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            done_q      <= done_d;
            short_q     <= short_d;
            remaining_q <= remaining_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    // Working registers only matter once a request has been latched in IDLE.
    always_ff @(posedge clk) begin
        coin_q <= coin_d;
        rem_q  <= rem_d;
        gap_q  <= gap_d;
    end

    assign outquarter = out_q[2];
    assign outdime    = out_q[1];
    assign outnickel  = out_q[0];
    assign done       = done_q;
    assign short_chg  = short_q;
    assign remaining  = remaining_q;
    assign req_ready  = ready_q;
    assign busy       = busy_q;

`ifdef CHANGE_EMPTY_FLAGS_EN
    localparam logic [2:0] EMPTY_INIT = {INIT_Q == 0, INIT_D == 0, INIT_N == 0};

    logic [2:0] coin_empty_q;
    logic [2:0] coin_empty_d;

    assign coin_empty_d = {q_empty, d_empty, n_empty};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coin_empty_q <= EMPTY_INIT;
        end else begin
            coin_empty_q <= coin_empty_d;
        end
    end

    assign coin_empty = coin_empty_q;
`else
    // Without the flags the empty indications only steer coin selection.
`endif

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
    localparam int AMT_W = 8;
    localparam int CNT_W = 6;
    localparam int INIT  = 20;
    localparam int GAPC  = 1;
    localparam int SLOT  = 2 + GAPC;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             refill_q, refill_d, refill_n;
    logic             outquarter, outdime, outnickel;
    logic             busy, done, short_chg;
    logic [AMT_W-1:0] remaining;
`ifdef CHANGE_EMPTY_FLAGS_EN
    logic [2:0]       coin_empty;
`endif

    change_dispenser #(
        .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_Q(INIT), .INIT_D(INIT),
        .INIT_N(INIT), .PULSE_GAP(GAPC)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(req_ready), .refill_q(refill_q), .refill_d(refill_d),
        .refill_n(refill_n), .outquarter(outquarter), .outdime(outdime),
        .outnickel(outnickel), .busy(busy), .done(done), .short_chg(short_chg),
        .remaining(remaining)
`ifdef CHANGE_EMPTY_FLAGS_EN
        , .coin_empty(coin_empty)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Observed coin events: 0 = quarter, 1 = dime, 2 = nickel.
    int ev_coin[$];
    int ev_cyc[$];
    int done_cnt = 0;
    int done_cyc = 0;

    always @(negedge clk) begin
        if (outquarter || outdime || outnickel) begin
            chk("one_hot_out", int'(outquarter) + int'(outdime) + int'(outnickel), 1);
            ev_coin.push_back(outquarter ? 0 : (outdime ? 1 : 2));
            ev_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Reference inventory.
    int mq, md, mn;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic refill(input int which, input int k);
        for (int i = 0; i < k; i++) begin
            refill_q = (which == 0);
            refill_d = (which == 1);
            refill_n = (which == 2);
            step();
            refill_q = 1'b0;
            refill_d = 1'b0;
            refill_n = 1'b0;
            if (which == 0) mq = min2(mq + 1, CMAX);
            if (which == 1) md = min2(md + 1, CMAX);
            if (which == 2) mn = min2(mn + 1, CMAX);
        end
    endtask

    task automatic do_req(input int amt, input bit collide, input bit hold_valid);
        int nq, nd, nn, r, acc, waited;
        int exp_coin[$];
        waited = 0;
        while (!req_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        // Greedy payout from the specification's rules.
        nq = min2(amt / 25, mq);
        r  = amt - 25 * nq;
        nd = min2(r / 10, md);
        r  = r - 10 * nd;
        nn = min2(r / 5, mn);
        r  = r - 5 * nn;
        for (int i = 0; i < nq; i++) exp_coin.push_back(0);
        for (int i = 0; i < nd; i++) exp_coin.push_back(1);
        for (int i = 0; i < nn; i++) exp_coin.push_back(2);
        mq = mq - nq + (collide ? nq : 0);
        md = md - nd;
        mn = mn - nn;

        ev_coin.delete();
        ev_cyc.delete();
        done_cnt   = 0;
        acc        = cyc;
        req_valid  = 1'b1;
        req_amount = AMT_W'(amt);
        step();
        if (hold_valid) req_amount = AMT_W'(amt ^ 30);
        else req_valid = 1'b0;
        waited = 0;
        while (waited < 400) begin
            if (hold_valid) chk("ready_low_busy", int'(req_ready), 0);
            if (done_cnt != 0) break;
            step();
            refill_q = collide && outquarter;
            waited++;
        end
        refill_q  = 1'b0;
        req_valid = 1'b0;
        if (done_cnt == 0) begin
            chk("done_timeout", 0, 1);
            return;
        end
        chk("n_pulses", ev_coin.size(), exp_coin.size());
        for (int i = 0; i < ev_coin.size() && i < exp_coin.size(); i++) begin
            chk("coin_kind", ev_coin[i], exp_coin[i]);
            chk("coin_time", ev_cyc[i] - acc, 2 + i * SLOT);
        end
        chk("done_time", done_cyc - acc, 2 + exp_coin.size() * SLOT);
        chk("short_chg", int'(short_chg), int'(r != 0));
        chk("remaining", int'(remaining), r);
        chk("q_cnt", int'(dut.q_cnt), mq);
        chk("d_cnt", int'(dut.d_cnt), md);
        chk("n_cnt", int'(dut.n_cnt), mn);
        step();
        chk("done_one_cycle", int'(done), 0);
        chk("ready_after", int'(req_ready), 1);
        chk("busy_after", int'(busy), 0);
        chk("single_done", done_cnt, 1);
    endtask

    initial begin
        int amt;
        reset = 1'b1; req_valid = 1'b0; req_amount = '0;
        refill_q = 1'b0; refill_d = 1'b0; refill_n = 1'b0;
        mq = INIT; md = INIT; mn = INIT;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_outs", int'({outquarter, outdime, outnickel}), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_q_cnt", int'(dut.q_cnt), INIT);
        reset = 1'b0;
        step();

        do_req(105, 0, 0);
        do_req(0, 0, 0);
        do_req(7, 0, 1);
        do_req(25, 1, 0);
        refill(2, 70);
        chk("n_saturate", int'(dut.n_cnt), CMAX);

        // Reset in the middle of a 75-cent payout.
        ev_coin.delete();
        ev_cyc.delete();
        req_valid  = 1'b1;
        req_amount = AMT_W'(75);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 100 && ev_coin.size() < 2; i++) step();
        chk("mid_pulses", ev_coin.size(), 2);
        reset = 1'b1;
        #1;
        chk("async_out_drop", int'({outquarter, outdime, outnickel}), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_ready", int'(req_ready), 1);
        chk("async_q_cnt", int'(dut.q_cnt), INIT);
        chk("async_n_cnt", int'(dut.n_cnt), INIT);
        step();
        reset = 1'b0;
        mq = INIT; md = INIT; mn = INIT;
        ev_coin.delete();
        ev_cyc.delete();
        done_cnt = 0;
        repeat (20) step();
        chk("no_pulse_after_rst", ev_coin.size(), 0);
        chk("no_done_after_rst", done_cnt, 0);
        do_req(25, 0, 0);

        // Drain quarters to force dimes, nickels and short payouts.
        do_req(255, 0, 0);
        do_req(255, 0, 0);
        do_req(50, 0, 0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) refill(0, $urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) refill(1, $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) refill(2, $urandom_range(0, 3));
            amt = $urandom_range(0, 255);
            do_req(amt, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
